// File: rtl/comparador_serie_izq_der.sv
// MSB-first serial magnitude comparator: one bit pair per clock, 3-state EQ/LT/GT decision.
// Optional early termination when the result is decided: define COMPARADOR_SALIDA_TEMPRANA_EN.
module comparador_serie_izq_der #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic             a_le_b
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, SCAN} state_t;
  typedef enum logic [1:0] {CMP_EQ, CMP_LT, CMP_GT} cmp_t;

  state_t          state_q;
  cmp_t            cmp_q, cmp_d;
  logic [CW-1:0]   cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic            busy_q, done_q, valid_q;
  logic            lt_q, eq_q, gt_q, le_q;
  logic            finish;

  // The captured words are shifted left during the scan, so the bit under test is always the MSB.
  always_comb begin
    cmp_d = cmp_q;
    if (cmp_q == CMP_EQ) begin
      if (a_q[WIDTH-1] && !b_q[WIDTH-1]) begin
        cmp_d = CMP_GT;
      end else if (!a_q[WIDTH-1] && b_q[WIDTH-1]) begin
        cmp_d = CMP_LT;
      end
    end
  end

`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
  assign finish = (cnt_q == '0) || (cmp_d != CMP_EQ);
`else
  assign finish = (cnt_q == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmp_q   <= CMP_EQ;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN;
            a_q     <= a_in;
            b_q     <= b_in;
            cnt_q   <= CW'(WIDTH - 1);
            cmp_q   <= CMP_EQ;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            le_q    <= 1'b0;
          end
        end
        SCAN: begin
          cmp_q <= cmp_d;
          a_q   <= a_q << 1;
          b_q   <= b_q << 1;
          if (finish) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            lt_q    <= (cmp_d == CMP_LT);
            eq_q    <= (cmp_d == CMP_EQ);
            gt_q    <= (cmp_d == CMP_GT);
            le_q    <= (cmp_d != CMP_GT);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result_valid = valid_q;
  assign a_lt_b       = lt_q;
  assign a_eq_b       = eq_q;
  assign a_gt_b       = gt_q;
  assign a_le_b       = le_q;

endmodule

// File: tb/tb_comparador_serie_izq_der.sv
// Testbench for comparador_serie_izq_der (WIDTH=8): directed cases, mid-scan reset,
// held start with changing inputs, and random pairs checked through an expected-result queue.
module tb_comparador_serie_izq_der;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] aIn, bIn;
  logic             busy, done, resultValid, aLtB, aEqB, aGtB, aLeB;

  typedef struct {
    logic lt;
    logic eq;
    logic gt;
    int   lat;
  } exp_t;

  exp_t sb[$];
  int   testsRun  = 0;
  int   failCount = 0;

  comparador_serie_izq_der #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a_in        (aIn),
    .b_in        (bIn),
    .busy        (busy),
    .done        (done),
    .result_valid(resultValid),
    .a_lt_b      (aLtB),
    .a_eq_b      (aEqB),
    .a_gt_b      (aGtB),
    .a_le_b      (aLeB)
  );

  always #5 clk = ~clk;

  // Reference model: unsigned compare plus the number of compare edges until done.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int   k;
    e.lt = (a < b);
    e.eq = (a == b);
    e.gt = (a > b);
    k = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (a[i] != b[i]) break;
      k++;
    end
`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
    e.lat = (a == b) ? WIDTH : k + 1;
`else
    e.lat = WIDTH;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_busy"},  busy,        1'b0);
    check({tag, "_done"},  done,        1'b0);
    check({tag, "_valid"}, resultValid, 1'b0);
    check({tag, "_lt"},    aLtB,        1'b0);
    check({tag, "_eq"},    aEqB,        1'b0);
    check({tag, "_gt"},    aGtB,        1'b0);
    check({tag, "_le"},    aLeB,        1'b0);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start = 1'b1;
    aIn   = a;
    bIn   = b;
    sb.push_back(model(a, b));
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (n < 3 * WIDTH) begin
      @(posedge clk);
      #1;
      n++;
      check("busy_done_excl", busy & done, 1'b0);
      if (done) break;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic checkOutput(input int n);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_nonempty", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    check("latency", n,           e.lat);
    check("valid",   resultValid, 1'b1);
    check("busy_lo", busy,        1'b0);
    check("lt",      aLtB,        e.lt);
    check("eq",      aEqB,        e.eq);
    check("gt",      aGtB,        e.gt);
    check("le",      aLeB,        e.lt | e.eq);
    check("onehot",  aLtB + aEqB + aGtB, 1);
  endtask

  task automatic runCompare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    applyStimulus(a, b);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy,        1'b1);
    check("valid_cleared",    resultValid, 1'b0);
    waitDone(n);
    checkOutput(n);
    @(posedge clk);
    #1;
    check("done_one_cycle", done,        1'b0);
    check("valid_hold",     resultValid, 1'b1);
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] a1, b1;

    rst_n = 1'b0;
    start = 1'b0;
    aIn   = '0;
    bIn   = '0;
    #12;
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    runCompare(8'h5A, 8'h5A);
    runCompare(8'h80, 8'h7F);
    runCompare(8'h12, 8'h13);
    runCompare(8'h00, 8'hFF);
    runCompare(8'hFF, 8'hFF);
    runCompare(8'hC3, 8'hC1);

    // Asynchronous reset in the middle of a scan must abort without a done pulse.
    applyStimulus(8'h33, 8'h34);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("mid_reset");
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (WIDTH + 2) begin
      @(posedge clk);
      #1;
      check("no_done_after_abort", done, 1'b0);
    end
    runCompare(8'h34, 8'h33);

    // Start held high with inputs changing during the scan, then back-to-back restart.
    applyStimulus(8'hA5, 8'hA7);
    @(posedge clk);
    #1;
    n = 0;
    while (n < 3 * WIDTH) begin
      aIn = WIDTH'($urandom);
      bIn = WIDTH'($urandom);
      @(posedge clk);
      #1;
      n++;
      check("busy_done_excl", busy & done, 1'b0);
      if (done) break;
    end
    check("done_seen", done, 1'b1);
    checkOutput(n);
    a1 = 8'h0F;
    b1 = 8'h0E;
    applyStimulus(a1, b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy",  busy,        1'b1);
    check("b2b_valid", resultValid, 1'b0);
    waitDone(n);
    checkOutput(n);
    @(posedge clk);
    #1;

    for (int i = 0; i < 1000; i++) begin
      runCompare(WIDTH'($urandom), WIDTH'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
